// File: rtl/reg_dump_streamer.sv
// Streams every architectural register as a valid/ready beat sequence for debug dumps.
// Optional trailing XOR checksum beat enabled by REG_DUMP_STREAMER_CHECKSUM_EN.
`timescale 1ns/1ps
`default_nettype none

module reg_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_index,
  output logic [XLEN-1:0] out_data,
  output logic            out_last
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 1);

`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
  localparam logic [5:0] CSUM_IDX = 6'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  logic [XLEN-1:0] csum;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    DONE = 3'd4
  } state_t;
`endif

  state_t     state;
  state_t     state_next;
  logic [5:0] idx;
  logic       hs;
  logic       at_last;

  assign hs      = out_valid & out_ready;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (start) state_next = READ;
      READ: state_next = SEND;
      SEND: begin
        if (hs) begin
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
          state_next = at_last ? CSUM : READ;
`else
          state_next = at_last ? DONE : READ;
`endif
        end
      end
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
      CSUM: if (hs) state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= 6'd0;
      out_data  <= '0;
      rf_raddr  <= 5'd0;
      idx       <= 6'd0;
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_raddr <= 5'd0;
            idx      <= 6'd0;
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        READ: begin
          // Register 0 is hardwired zero, so its beat ignores whatever the RF returns.
          out_valid <= 1'b1;
          out_index <= idx;
          out_data  <= (idx == 6'd0) ? '0 : rf_rdata;
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= at_last;
`endif
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
            csum      <= csum ^ out_data;
`endif
            if (!at_last) begin
              idx      <= idx + 6'd1;
              rf_raddr <= rf_raddr + 5'd1;
            end
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
            else begin
              // Checksum beat follows the last register back-to-back.
              out_valid <= 1'b1;
              out_index <= CSUM_IDX;
              out_data  <= csum ^ out_data;
              out_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer: table-driven dumps plus stall, restart and reset sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_reg_dump_streamer;

`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
  localparam int DUMP_BEATS = 33;
  localparam int DONE_T     = 66;
`else
  localparam int DUMP_BEATS = 32;
  localparam int DONE_T     = 65;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;

  reg_dump_streamer #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  always_comb rf_rdata = rf[rf_raddr];

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
    int          t;
  } beat_t;

  typedef struct {
    logic [31:0] r0, r1, r2, r3, r4;
    logic        rand_ready;
    logic [31:0] exp_csum;
    int          exp_beats;
  } vec_t;

  beat_t sbq[$];
  vec_t  vecs[3];

  int tests = 0;
  int fails = 0;
  int ncount = 0;
  int start_n = 0;
  int mon_t;
  int beats = 0;
  int dones = 0;
  int exp_done_t = -1;
  int ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, mon_t);
    end
  endtask

  function automatic logic [31:0] model_csum();
    logic [31:0] x = '0;
    for (int k = 1; k < 32; k++) x ^= rf[k];
    return x;
  endfunction

  task automatic push_dump(input bit timed, input logic [31:0] csum);
    beat_t b;
    for (int k = 0; k < 32; k++) begin
      b.idx  = 6'(k);
      b.data = (k == 0) ? 32'h0 : rf[k];
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == 31);
`endif
      b.t    = timed ? (2 * k + 2) : -1;
      sbq.push_back(b);
    end
`ifdef REG_DUMP_STREAMER_CHECKSUM_EN
    b.idx  = 6'h20;
    b.data = csum;
    b.last = 1'b1;
    b.t    = timed ? 65 : -1;
    sbq.push_back(b);
`endif
  endtask

  task automatic start_dump(input bit timed, input logic [31:0] csum);
    start_n    = ncount + 1;
    exp_done_t = timed ? DONE_T : -1;
    push_dump(timed, csum);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (dones >= target) break;
    end
    check("done_seen", 64'(dones), 64'(target));
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic wait_beat(input logic [5:0] which);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == which) begin
        found = 1'b1;
        break;
      end
    end
    check("beat_reached", 64'(found), 64'd1);
  endtask

  task automatic load_rf(input logic [31:0] r0, r1, r2, r3, r4);
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    rf[0] = r0; rf[1] = r1; rf[2] = r2; rf[3] = r3; rf[4] = r4;
  endtask

  // Ready driver sits 2 time units after the edge so sequences at +1 can retarget it.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshakes, stall stability and done pulses, sampled on the falling edge.
  initial begin
    beat_t       exp_b;
    bit          hold = 1'b0;
    logic [5:0]  h_idx;
    logic [31:0] h_data;
    logic        h_last;
    forever begin
      @(negedge clk);
      ncount++;
      mon_t = ncount - start_n;
      if (!reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_index", 64'(out_index), 64'(h_idx));
          check("stall_data", 64'(out_data), 64'(h_data));
          check("stall_last", 64'(out_last), 64'(h_last));
        end
        hold   = out_valid && !out_ready;
        h_idx  = out_index;
        h_data = out_data;
        h_last = out_last;
        if (out_valid && out_ready) begin
          beats++;
          if (sbq.size() == 0) begin
            check("unexpected_beat", 64'(out_index), 64'h3f);
          end else begin
            exp_b = sbq.pop_front();
            check("beat_index", 64'(out_index), 64'(exp_b.idx));
            check("beat_data", 64'(out_data), 64'(exp_b.data));
            check("beat_last", 64'(out_last), 64'(exp_b.last));
            if (exp_b.t >= 0) check("beat_cycle", 64'(mon_t), 64'(exp_b.t));
          end
        end
        if (done) begin
          dones++;
          check("done_busy", 64'(busy), 64'd1);
          if (exp_done_t >= 0) check("done_cycle", 64'(mon_t), 64'(exp_done_t));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int b0;
    vecs[0] = '{32'h0, 32'hF, 32'h5, 32'hA, 32'h14, 1'b0, 32'h14, DUMP_BEATS};
    vecs[1] = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h4, 32'h8, 1'b0, 32'hF, DUMP_BEATS};
    vecs[2] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h0, 1'b1, 32'h12345678, DUMP_BEATS};

    reset = 1'b0;
    start = 1'b0;
    load_rf(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_raddr", 64'(rf_raddr), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      load_rf(vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3, vecs[v].r4);
      ready_mode = vecs[v].rand_ready ? 1 : 0;
      d0 = dones;
      b0 = beats;
      start_dump(!vecs[v].rand_ready, vecs[v].exp_csum);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done(d0 + 1);
      check("beat_count", 64'(beats - b0), 64'(vecs[v].exp_beats));
      check("sb_empty", 64'(sbq.size()), 64'd0);
      ready_mode = 0;
      @(posedge clk); #1;
    end

    // Backpressure on beat 2 for five cycles.
    load_rf(32'h0, 32'hF, 32'h5, 32'hA, 32'h14);
    d0 = dones;
    start_dump(1'b0, model_csum());
    wait_beat(6'd2);
    ready_mode = 2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_index", 64'(out_index), 64'd2);
      check("hold_data", 64'(out_data), 64'h5);
    end
    ready_mode = 0;
    @(posedge clk); #1;
    check("gap_after_hs", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("next_valid", 64'(out_valid), 64'd1);
    check("next_index", 64'(out_index), 64'd3);
    wait_done(d0 + 1);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    // Start pulsed mid-dump is ignored.
    d0 = dones;
    b0 = beats;
    start_dump(1'b1, model_csum());
    wait_beat(6'd10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0 + 1);
    check("restart_beats", 64'(beats - b0), 64'(DUMP_BEATS));
    repeat (5) @(posedge clk);
    #1;
    check("restart_dones", 64'(dones - d0), 64'd1);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    // Reset while beat 10 is valid aborts without done.
    start_dump(1'b0, model_csum());
    wait_beat(6'd10);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    sbq.delete();
    d0 = dones;
    b0 = beats;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(dones), 64'(d0));
    check("abort_no_beats", 64'(beats), 64'(b0));
    start_dump(1'b1, model_csum());
    wait_done(d0 + 1);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    // Start held across DONE chains a second dump from IDLE.
    load_rf(32'h0, 32'h11, 32'h22, 32'h44, 32'h88);
    d0 = dones;
    start_n    = ncount + 1;
    exp_done_t = -1;
    push_dump(1'b0, model_csum());
    push_dump(1'b0, model_csum());
    start = 1'b1;
    wait_done(d0 + 1);
    @(posedge clk); #1;
    check("chain_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(d0 + 2);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
